// File: rtl/bits_correlator_if.sv
// Sample-in / correlation-out bundle for the FM0 bit correlator.
// The front end drives samples as master; the correlator answers as slave.
interface bits_correlator_if #(
   parameter int BANK_WIDTH = 2,
   parameter int CORR_WIDTH = 3
);
   logic                    in_dat;
   logic                    in_vld;
   logic [BANK_WIDTH-1:0]   frequency_bank;
   logic [4*CORR_WIDTH-1:0] corr_dat;
   logic                    corr_vld;

   modport master (
      output in_dat,
      output in_vld,
      output frequency_bank,
      input  corr_dat,
      input  corr_vld
   );

   modport slave (
      input  in_dat,
      input  in_vld,
      input  frequency_bank,
      output corr_dat,
      output corr_vld
   );
endinterface

// File: rtl/bits_correlator.sv
// Sliding-window matched-filter bank for FM0 bit decoding.
// Four template match counts over the newest L samples, L chosen per bank.
module bits_correlator #(
   parameter int LENGTH = 4,
   parameter int BANKS  = 4,
   // Window-length table, entry b at [b*CW +: CW]; this default must
   // stay in step with bits_correlator_lengths.mem used by the detector.
   parameter logic [BANKS*$clog2(LENGTH+1)-1:0] LENGTHS =
      {3'd4, 3'd3, 3'd2, 3'd4}
) (
   input logic               clk,
   input logic               rst,
   bits_correlator_if.slave  bus
);

   localparam int BW = $clog2(BANKS);
   localparam int CW = $clog2(LENGTH + 1);
   localparam logic [CW-1:0] MAX_L = CW'(LENGTH);

   logic [LENGTH-1:0] hist;
   logic [LENGTH-1:0] hist_next;
   logic [CW-1:0]     raw_len;
   logic [CW-1:0]     win_len;
   logic [CW-1:0]     half_len;
   logic [CW-1:0]     old_start;
   logic [CW-1:0]     s1;
   logic [CW-1:0]     s2;
   logic [CW-1:0]     s3;
   logic [CW-1:0]     s4;
   logic [4*CW-1:0]   corr_q;
   logic              vld_q;

   // Look up the raw window length for the selected bank.
   always_comb begin
      raw_len = '0;
      for (int b = 0; b < BANKS; b++) begin
         if (bus.frequency_bank == BW'(b)) begin
            raw_len = LENGTHS[b*CW +: CW];
         end
      end
   end

   // Clamp the length; zero or oversize entries mean the full register.
   always_comb begin
      if (raw_len == '0 || raw_len > MAX_L) begin
         win_len = MAX_L;
      end else begin
         win_len = raw_len;
      end
      half_len  = win_len >> 1;
      old_start = win_len - half_len;
   end

   // History as it will look once the current sample is shifted in.
   always_comb begin
      hist_next = LENGTH'({hist, bus.in_dat});
   end

   // Count template matches over the window, newest sample at index 0.
   always_comb begin
      s1 = '0;
      s2 = '0;
      for (int i = 0; i < LENGTH; i++) begin
         if (CW'(i) < win_len) begin
            s1 = s1 + CW'(hist_next[i]);
            if (CW'(i) >= old_start) begin
               s2 = s2 + CW'(hist_next[i]);
            end else begin
               s2 = s2 + CW'(!hist_next[i]);
            end
         end
      end
      s4 = win_len - s1;
      s3 = win_len - s2;
   end

   // Shift history and register a fresh result for each valid sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist   <= '0;
         corr_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= bus.in_vld;
         if (bus.in_vld) begin
            hist   <= hist_next;
            corr_q <= {s4, s3, s2, s1};
         end
      end
   end

   assign bus.corr_dat = corr_q;
   assign bus.corr_vld = vld_q;

endmodule

// File: tb/tb_bits_correlator.sv
// Bench for bits_correlator: reference model feeds a scoreboard queue,
// each scenario task pops and compares as results appear.
module tb_bits_correlator;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   bits_correlator_if #(.BANK_WIDTH(2), .CORR_WIDTH(3)) bus ();

   bits_correlator #(.LENGTH(4), .BANKS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          errors = 0;
   int          checks = 0;
   int          tbl[4] = '{4, 2, 3, 4};
   logic [3:0]  mh = '0;
   logic [11:0] sb[$];
   logic [11:0] last = '0;
   logic [11:0] exp_v;

   function automatic logic [11:0] pack(input int a, input int b,
                                        input int c, input int d);
      return {3'(d), 3'(c), 3'(b), 3'(a)};
   endfunction

   // Templates taken literally: oldest H positions of S2 are ones.
   function automatic logic [11:0] model(input logic [3:0] h, input int bank);
      int l;
      int hh;
      int m1;
      int m2;
      logic t2;
      l = tbl[bank];
      if (l == 0 || l > 4) l = 4;
      hh = l / 2;
      m1 = 0;
      m2 = 0;
      for (int p = 0; p < l; p++) begin
         t2 = (p >= l - hh);
         if (h[p] == 1'b1) m1++;
         if (h[p] == t2) m2++;
      end
      return pack(m1, m2, l - m2, l - m1);
   endfunction

   task automatic send(input logic d, input int bank);
      @(negedge clk);
      bus.in_vld = 1'b1;
      bus.in_dat = d;
      bus.frequency_bank = 2'(bank);
      mh = {mh[2:0], d};
      sb.push_back(model(mh, bank));
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      @(negedge clk);
      bus.in_vld = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.corr_vld !== 1'b0) begin
         errors++;
         $display("FAIL reset_vld got=%b exp=0", bus.corr_vld);
      end
      checks++;
      if (bus.corr_dat !== 12'h000) begin
         errors++;
         $display("FAIL reset_dat got=%h exp=000", bus.corr_dat);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_all_ones();
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 0);
         checks++;
         if (bus.corr_vld !== 1'b1) begin
            errors++;
            $display("FAIL ones_vld got=%b exp=1", bus.corr_vld);
         end
         exp_v = sb.pop_front();
         last = exp_v;
         checks++;
         if (bus.corr_dat !== exp_v) begin
            errors++;
            $display("FAIL ones_dat got=%h exp=%h", bus.corr_dat, exp_v);
         end
      end
      checks++;
      if (bus.corr_dat !== pack(4, 2, 2, 0)) begin
         errors++;
         $display("FAIL ones_final got=%h exp=%h",
                  bus.corr_dat, pack(4, 2, 2, 0));
      end
   endtask

   task automatic test_edges();
      int pa[8] = '{1, 1, 0, 0, 0, 0, 1, 1};
      for (int i = 0; i < 8; i++) begin
         send(pa[i][0], 0);
         checks++;
         if (bus.corr_vld !== 1'b1) begin
            errors++;
            $display("FAIL edge_vld i=%0d got=%b exp=1", i, bus.corr_vld);
         end
         exp_v = sb.pop_front();
         last = exp_v;
         checks++;
         if (bus.corr_dat !== exp_v) begin
            errors++;
            $display("FAIL edge_dat i=%0d got=%h exp=%h",
                     i, bus.corr_dat, exp_v);
         end
         if (i == 3) begin
            checks++;
            if (bus.corr_dat !== pack(2, 4, 0, 2)) begin
               errors++;
               $display("FAIL edge_fall got=%h exp=%h",
                        bus.corr_dat, pack(2, 4, 0, 2));
            end
         end
      end
      checks++;
      if (bus.corr_dat !== pack(2, 0, 4, 2)) begin
         errors++;
         $display("FAIL edge_rise got=%h exp=%h",
                  bus.corr_dat, pack(2, 0, 4, 2));
      end
   endtask

   task automatic test_bank1();
      send(1'b1, 1);
      void'(sb.pop_front());
      send(1'b0, 1);
      exp_v = sb.pop_front();
      checks++;
      if (bus.corr_dat !== exp_v || bus.corr_dat !== pack(1, 2, 0, 1)) begin
         errors++;
         $display("FAIL bank1_dat got=%h exp=%h", bus.corr_dat, exp_v);
      end
      @(negedge clk);
      bus.in_vld = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mh = '0;
      sb.delete();
      send(1'b1, 1);
      exp_v = sb.pop_front();
      last = exp_v;
      checks++;
      if (bus.corr_vld !== 1'b1) begin
         errors++;
         $display("FAIL prefill_vld got=%b exp=1", bus.corr_vld);
      end
      checks++;
      if (bus.corr_dat !== exp_v || bus.corr_dat !== pack(1, 0, 2, 1)) begin
         errors++;
         $display("FAIL prefill_dat got=%h exp=%h", bus.corr_dat, exp_v);
      end
   endtask

   task automatic test_gapped();
      int pa[3] = '{1, 0, 0};
      for (int i = 0; i < 3; i++) begin
         send(pa[i][0], 2);
         checks++;
         if (bus.corr_vld !== 1'b1) begin
            errors++;
            $display("FAIL gap_vld i=%0d got=%b exp=1", i, bus.corr_vld);
         end
         exp_v = sb.pop_front();
         last = exp_v;
         checks++;
         if (bus.corr_dat !== exp_v) begin
            errors++;
            $display("FAIL gap_dat i=%0d got=%h exp=%h",
                     i, bus.corr_dat, exp_v);
         end
         quiet();
         for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.corr_vld !== 1'b0 || bus.corr_dat !== last) begin
               errors++;
               $display("FAIL gap_hold i=%0d vld=%b dat=%h exp=0/%h",
                        i, bus.corr_vld, bus.corr_dat, last);
            end
         end
      end
      checks++;
      if (last !== pack(1, 3, 0, 2) || bus.corr_dat !== pack(1, 3, 0, 2)) begin
         errors++;
         $display("FAIL gap_final got=%h exp=%h",
                  bus.corr_dat, pack(1, 3, 0, 2));
      end
   endtask

   task automatic test_bank_switch();
      int pa[4] = '{0, 1, 1, 0};
      for (int i = 0; i < 4; i++) begin
         send(pa[i][0], 0);
         exp_v = sb.pop_front();
         checks++;
         if (bus.corr_dat !== exp_v) begin
            errors++;
            $display("FAIL sw_hist i=%0d got=%h exp=%h",
                     i, bus.corr_dat, exp_v);
         end
      end
      send(1'b1, 1);
      exp_v = sb.pop_front();
      last = exp_v;
      checks++;
      if (bus.corr_dat !== exp_v || bus.corr_dat !== pack(1, 0, 2, 1)) begin
         errors++;
         $display("FAIL sw_dat got=%h exp=%h", bus.corr_dat, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic d;
      int   b;
      for (int i = 0; i < 12; i++) begin
         d = 1'($urandom_range(0, 1));
         b = int'($urandom_range(0, 3));
         send(d, b);
         checks++;
         if (bus.corr_vld !== 1'b1) begin
            errors++;
            $display("FAIL b2b_vld i=%0d got=%b exp=1", i, bus.corr_vld);
         end
         exp_v = sb.pop_front();
         last = exp_v;
         checks++;
         if (bus.corr_dat !== exp_v) begin
            errors++;
            $display("FAIL b2b_dat i=%0d bank=%0d got=%h exp=%h",
                     i, b, bus.corr_dat, exp_v);
         end
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      bus.in_vld = 1'b1;
      bus.in_dat = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.corr_vld !== 1'b0 || bus.corr_dat !== 12'h000) begin
         errors++;
         $display("FAIL mid_rst_now vld=%b dat=%h exp=0/000",
                  bus.corr_vld, bus.corr_dat);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.corr_vld !== 1'b0 || bus.corr_dat !== 12'h000) begin
            errors++;
            $display("FAIL mid_rst_hold vld=%b dat=%h exp=0/000",
                     bus.corr_vld, bus.corr_dat);
         end
      end
      @(negedge clk);
      bus.in_vld = 1'b0;
      rst = 1'b0;
      mh = '0;
      sb.delete();
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.corr_vld !== 1'b0 || bus.corr_dat !== 12'h000) begin
            errors++;
            $display("FAIL idle vld=%b dat=%h exp=0/000",
                     bus.corr_vld, bus.corr_dat);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_vld = 1'b0;
      bus.in_dat = 1'b0;
      bus.frequency_bank = 2'd0;
      test_reset();
      test_all_ones();
      test_edges();
      test_bank1();
      test_gapped();
      test_bank_switch();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
